// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INSN_BYTES = 4;
    localparam logic [XLEN-1:0] NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries between fetch and decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           pushData,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   headValid,
    output fetch_entry_t           headData,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic          doPush;
    logic          doPop;

    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign doPop  = pop && (count != '0);
    assign doPush = push && ((count < CW'(DEPTH)) || doPop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush && !rst) begin
            mem[wrPtr] <= pushData;
        end
    end

    assign headValid = (count != '0);
    assign headData  = mem[rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch initiator: PC register, fetch FSM, response acceptance and decode-side queue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:0]            memAddr,
    input  logic [31:0]            memDout,
    input  logic [31:0]            memAddrOut,
    input  logic                   memReadValid,
    input  logic                   memReady,
    output logic                   instValid,
    output logic [31:0]            instData,
    output logic [31:0]            instPc,
    input  logic                   instReady,
    input  logic                   redirectValid,
    input  logic [31:0]            redirectPc,
    input  logic                   haltReq,
    output logic [$clog2(DEPTH):0] queueCount,
    output logic [31:0]            fetchCount
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] BOOT_PC = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            pop;
    logic            accept;
    logic            headValid;
    fetch_entry_t    head;
    fetch_entry_t    pushEntry;

    assign pop = headValid && instReady;

    // Only a response echoing the current pc, with room in the queue, advances fetch.
    assign accept = (state == FETCH) && !haltReq && !redirectValid
                 && memReady && memReadValid && (memAddrOut == pc)
                 && ((queueCount < CW'(DEPTH)) || pop);

    assign pushEntry = '{pc: pc, instr: memDout};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= BOOT_PC;
            fetchCount <= '0;
        end else if (redirectValid) begin
            state <= haltReq ? HOLD : FETCH;
            pc    <= alignPc(redirectPc);
        end else begin
            unique case (state)
                BOOT:    state <= FETCH;
                FETCH:   if (haltReq) state <= HOLD;
                HOLD:    if (!haltReq) state <= FETCH;
                default: state <= BOOT;
            endcase
            if (accept) begin
                pc         <= pc + XLEN'(INSN_BYTES);
                fetchCount <= fetchCount + 32'd1;
            end
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) uQueue (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .pushData (pushEntry),
        .pop      (pop),
        .flush    (redirectValid),
        .headValid(headValid),
        .headData (head),
        .count    (queueCount)
    );

    assign memAddr   = pc;
    assign instValid = headValid;
    assign instData  = headValid ? head.instr : '0;
    assign instPc    = headValid ? head.pc : '0;

endmodule
